// File: rtl/conditioner_pkg.sv
// Shared types and constants for the conditioner event arbiter.
// Holds the FSM encoding, the default channel count and the event polarity codes.
package conditioner_pkg;

    localparam int DEFAULT_NUM_CH = 4;

    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/conditioner_event_arbiter_if.sv
// Edge-pulse inputs, valid/ready event output and sticky overflow flags.
// The arbiter takes the master side; conditioners and the event consumer form the slave side.
interface conditioner_event_arbiter_if
    import conditioner_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CH_W   = 2
) ();

    logic [NUM_CH-1:0] positiveedge;
    logic [NUM_CH-1:0] negativeedge;
    logic              evt_ready;
    logic              overflow_clear;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_rise;
    logic [NUM_CH-1:0] overflow;

    modport master (
        input  positiveedge, negativeedge, evt_ready, overflow_clear,
        output evt_valid, evt_ch, evt_rise, overflow
    );

    modport slave (
        output positiveedge, negativeedge, evt_ready, overflow_clear,
        input  evt_valid, evt_ch, evt_rise, overflow
    );

endinterface

// File: rtl/conditioner_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or after ptr, wrapping.
// Zero latency; no state, so no backpressure of its own.
module rr_pick
    import conditioner_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_req
);

    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    logic [2*NUM_CH-1:0] req2;
    logic [NUM_CH-1:0]   rot;
    logic [CH_W-1:0]     off;
    logic [CH_W:0]       sum;

    // Rotate so bit 0 is the pointer position; the lowest set bit is then the winner.
    assign req2 = {req, req};
    assign rot  = req2[ptr +: NUM_CH];

    always_comb begin
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = CH_W'(i);
            end
        end
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign grant   = (sum >= NCH) ? CH_W'(sum - NCH) : sum[CH_W-1:0];
    assign any_req = |req;

endmodule

// File: rtl/conditioner_event_arbiter.sv
// Latches per-channel edge pulses and serialises them round-robin onto one valid/ready port.
// Pulse to evt_valid is 2 cycles when idle; payload holds while evt_ready is low, back-to-back on accept.
module conditioner_event_arbiter
    import conditioner_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CH_W   = 2
) (
    input  logic clk,
    input  logic reset,
    conditioner_event_arbiter_if.master bus
);

    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    arb_state_t        state, state_nxt;
    logic [NUM_CH-1:0] pend_r, pend_f, order, ovf;
    logic [NUM_CH-1:0] pend_r_nxt, pend_f_nxt, order_nxt;
    logic [NUM_CH-1:0] sel_oh, load_r, load_f, rem_r, rem_f, ovf_set;
    logic [CH_W-1:0]   rr_ptr, ptr_nxt, grant, evt_ch_q;
    logic [CH_W:0]     grant_inc;
    logic              evt_rise_q, any_req, load, sel_rise;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req     (pend_r | pend_f),
        .ptr     (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.evt_ready) begin
                    if (any_req) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Rise wins when it is the only flag or the older of the two.
    assign sel_oh    = NUM_CH'(1) << grant;
    assign sel_rise  = pend_r[grant] & (~pend_f[grant] | order[grant]);
    assign load_r    = (load &&  sel_rise) ? sel_oh : '0;
    assign load_f    = (load && !sel_rise) ? sel_oh : '0;
    assign grant_inc = {1'b0, grant} + (CH_W+1)'(1);
    assign ptr_nxt   = (grant_inc == NCH) ? '0 : grant_inc[CH_W-1:0];

    // A flag being loaded this cycle frees its slot, so a same-flag pulse is a fresh capture.
    assign rem_r      = pend_r & ~load_r;
    assign rem_f      = pend_f & ~load_f;
    assign ovf_set    = (bus.positiveedge & rem_r) | (bus.negativeedge & rem_f);
    assign pend_r_nxt = rem_r | bus.positiveedge;
    assign pend_f_nxt = rem_f | bus.negativeedge;

    always_comb begin
        order_nxt = order;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rem_r[c] ^ rem_f[c]) begin
                order_nxt[c] = rem_r[c];
            end else if (!rem_r[c] && !rem_f[c]) begin
                if (bus.positiveedge[c]) begin
                    order_nxt[c] = EVT_RISE;
                end else if (bus.negativeedge[c]) begin
                    order_nxt[c] = EVT_FALL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend_r     <= '0;
            pend_f     <= '0;
            order      <= '0;
            ovf        <= '0;
            rr_ptr     <= '0;
            evt_ch_q   <= '0;
            evt_rise_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend_r <= pend_r_nxt;
            pend_f <= pend_f_nxt;
            order  <= order_nxt;
            ovf    <= (ovf & ~{NUM_CH{bus.overflow_clear}}) | ovf_set;
            if (load) begin
                evt_ch_q   <= grant;
                evt_rise_q <= sel_rise;
                rr_ptr     <= ptr_nxt;
            end
        end
    end

    assign bus.evt_valid = (state == PRESENT);
    assign bus.evt_ch    = evt_ch_q;
    assign bus.evt_rise  = evt_rise_q;
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_conditioner_event_arbiter.sv
// Bench for conditioner_event_arbiter: vector table, directed corner sequences, random traffic.
// A per-channel pending-list model tracks expected outputs every cycle.
module tb_conditioner_event_arbiter;
    import conditioner_pkg::*;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int NV = 17;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    conditioner_event_arbiter_if #(.NUM_CH(N), .CH_W(W)) bus ();

    conditioner_event_arbiter #(.NUM_CH(N), .CH_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: each channel keeps an arrival-ordered list of pending polarities.
    bit         m_valid;
    int         m_ch;
    bit         m_rise;
    bit [N-1:0] m_ovf;
    int         m_ptr;
    bit         pq [N][2];
    int         pn [N];

    function automatic void model_reset();
        m_valid = 0;
        m_ch    = 0;
        m_rise  = 0;
        m_ovf   = '0;
        m_ptr   = 0;
        for (int c = 0; c < N; c++) pn[c] = 0;
    endfunction

    function automatic bit in_queue(int c, bit p);
        for (int i = 0; i < pn[c]; i++) if (pq[c][i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(bit [N-1:0] pos, bit [N-1:0] neg, bit rdy, bit clr, bit rst);
        bit [N-1:0] newov;
        bit         any;
        int         c;
        if (rst) begin
            model_reset();
            return;
        end
        any = 0;
        for (int k = 0; k < N; k++) if (pn[k] > 0) any = 1;
        if (!m_valid || rdy) begin
            if (any) begin
                c = -1;
                for (int k = 0; k < N; k++) begin
                    int cc;
                    cc = (m_ptr + k) % N;
                    if (c < 0 && pn[cc] > 0) c = cc;
                end
                m_ch     = c;
                m_rise   = pq[c][0];
                pq[c][0] = pq[c][1];
                pn[c]    = pn[c] - 1;
                m_ptr    = (c + 1) % N;
                m_valid  = 1;
            end else begin
                m_valid = 0;
            end
        end
        newov = '0;
        for (int k = 0; k < N; k++) begin
            if (pos[k]) begin
                if (in_queue(k, 1'b1)) newov[k] = 1'b1;
                else begin pq[k][pn[k]] = 1'b1; pn[k] = pn[k] + 1; end
            end
            if (neg[k]) begin
                if (in_queue(k, 1'b0)) newov[k] = 1'b1;
                else begin pq[k][pn[k]] = 1'b0; pn[k] = pn[k] + 1; end
            end
        end
        m_ovf = (m_ovf & ~{N{clr}}) | newov;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic [N-1:0] p, logic [N-1:0] n, logic rdy, logic clr, logic rs);
        bus.positiveedge   = p;
        bus.negativeedge   = n;
        bus.evt_ready      = rdy;
        bus.overflow_clear = clr;
        reset              = rs;
    endtask

    // One clock: advance the model with the driven inputs, then compare after the edge.
    task automatic tick();
        model_step(bus.positiveedge, bus.negativeedge, bus.evt_ready, bus.overflow_clear, reset);
        @(posedge clk);
        #1;
        check("model_valid", int'(bus.evt_valid), int'(m_valid));
        if (m_valid) begin
            check("model_ch", int'(bus.evt_ch), m_ch);
            check("model_rise", int'(bus.evt_rise), int'(m_rise));
        end
        check("model_ovf", int'(bus.overflow), int'(m_ovf));
    endtask

    typedef struct {
        logic [N-1:0] pos;
        logic [N-1:0] neg;
        logic         rst;
        logic         exp_valid;
        logic         chk_pl;
        int           exp_ch;
        logic         exp_rise;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(logic [N-1:0] p, logic [N-1:0] n, logic rs, logic v, int ch, logic r);
        vec_t e;
        e.pos = p; e.neg = n; e.rst = rs;
        e.exp_valid = v; e.chk_pl = v; e.exp_ch = ch; e.exp_rise = r;
        return e;
    endfunction

    initial begin
        vt[0]  = mk(4'b0100, 4'b0000, 0, 0, 0, 0);
        vt[1]  = mk(4'b0000, 4'b0000, 0, 1, 2, 1);
        vt[2]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0);
        vt[3]  = mk(4'b0000, 4'b0000, 1, 0, 0, 0);
        vt[4]  = mk(4'b1001, 4'b0000, 0, 0, 0, 0);
        vt[5]  = mk(4'b0000, 4'b0000, 0, 1, 0, 1);
        vt[6]  = mk(4'b0000, 4'b0000, 0, 1, 3, 1);
        vt[7]  = mk(4'b0011, 4'b0000, 0, 0, 0, 0);
        vt[8]  = mk(4'b0000, 4'b0000, 0, 1, 0, 1);
        vt[9]  = mk(4'b0000, 4'b0000, 0, 1, 1, 1);
        vt[10] = mk(4'b0011, 4'b0000, 0, 0, 0, 0);
        vt[11] = mk(4'b0000, 4'b0000, 0, 1, 0, 1);
        vt[12] = mk(4'b0000, 4'b0000, 0, 1, 1, 1);
        vt[13] = mk(4'b0000, 4'b0000, 0, 0, 0, 0);
        vt[14] = mk(4'b0000, 4'b0100, 0, 0, 0, 0);
        vt[15] = mk(4'b0000, 4'b0000, 0, 1, 2, 0);
        vt[16] = mk(4'b0000, 4'b0000, 0, 0, 0, 0);

        drive('0, '0, 1'b0, 1'b0, 1'b1);
        model_reset();
        tick();
        tick();
        check("reset_valid", int'(bus.evt_valid), 0);
        check("reset_ch", int'(bus.evt_ch), 0);
        check("reset_rise", int'(bus.evt_rise), 0);
        check("reset_ovf", int'(bus.overflow), 0);

        // Single event, round robin and falling edge from the table.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].pos, vt[i].neg, 1'b1, 1'b0, vt[i].rst);
            tick();
            check($sformatf("vec%0d_valid", i), int'(bus.evt_valid), int'(vt[i].exp_valid));
            if (vt[i].chk_pl) begin
                check($sformatf("vec%0d_ch", i), int'(bus.evt_ch), vt[i].exp_ch);
                check($sformatf("vec%0d_rise", i), int'(bus.evt_rise), int'(vt[i].exp_rise));
            end
            check($sformatf("vec%0d_ovf", i), int'(bus.overflow), 0);
        end

        // Backpressure: payload held, then the later fall on the same channel follows.
        drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.negativeedge = (i == 4) ? 4'b0010 : 4'b0000;
            tick();
            if (i >= 1) begin
                check("hold_valid", int'(bus.evt_valid), 1);
                check("hold_ch", int'(bus.evt_ch), 1);
                check("hold_rise", int'(bus.evt_rise), 1);
            end
        end
        bus.evt_ready = 1'b1;
        tick();
        check("bp_second_valid", int'(bus.evt_valid), 1);
        check("bp_second_ch", int'(bus.evt_ch), 1);
        check("bp_second_rise", int'(bus.evt_rise), 0);
        tick();
        check("bp_drained", int'(bus.evt_valid), 0);

        // Overflow: the second pulse refills the freed flag, the third is merged and flagged.
        drive(4'b1000, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("ovf_presented_ch", int'(bus.evt_ch), 3);
        bus.positiveedge = 4'b1000;
        tick();
        bus.positiveedge = '0;
        check("ovf_second_none", int'(bus.overflow), 0);
        for (int i = 0; i < 3; i++) tick();
        bus.positiveedge = 4'b1000;
        tick();
        bus.positiveedge = '0;
        check("ovf_third_set", int'(bus.overflow), 8);
        bus.overflow_clear = 1'b1;
        tick();
        check("ovf_cleared", int'(bus.overflow), 0);
        bus.positiveedge = 4'b1000;
        tick();
        bus.positiveedge   = '0;
        bus.overflow_clear = 1'b0;
        check("ovf_set_beats_clear", int'(bus.overflow), 8);
        bus.overflow_clear = 1'b1;
        tick();
        bus.overflow_clear = 1'b0;
        bus.evt_ready      = 1'b1;
        tick();
        check("ovf_merged_valid", int'(bus.evt_valid), 1);
        check("ovf_merged_ch", int'(bus.evt_ch), 3);
        tick();
        check("ovf_drained", int'(bus.evt_valid), 0);

        // Reset mid-operation discards presented and pending events and the overflow flags.
        drive(4'b0111, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.positiveedge = 4'b0111;
        tick();
        bus.positiveedge = '0;
        check("midrst_pre_valid", int'(bus.evt_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", int'(bus.evt_valid), 0);
        check("midrst_ovf", int'(bus.overflow), 0);
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_quiet", int'(bus.evt_valid), 0);
        end

        // A pulse coincident with reset is dropped.
        drive(4'b0001, '0, 1'b1, 1'b0, 1'b1);
        tick();
        drive('0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_edge_quiet", int'(bus.evt_valid), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(N'($urandom & $urandom), N'($urandom & $urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 199) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
